pwd_entry_ctrl: RTL
===================

Name: pwd_entry_ctrl

Overview:
Keypad-side controller for the digital lock. Collects two BCD digits into the 8-bit entered password (inpwd), holds the stored password (curpwd), and sends both to the combinational Compare block. It samples Compare's match result to open the lock, count failures, raise the alarm, and handle password changes while the lock is open.

Parameters:
DEFAULT_PWD, 8'h52, value loaded into curpwd at reset (digits 5,2)
MAX_FAIL, 3, consecutive failed checks that trigger the alarm
OPEN_CYCLES, 16, clocks the lock stays open without a key
ALARM_CYCLES, 32, clocks the alarm holds before returning to IDLE

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  4  0-9 digit; 4'hA enter; 4'hB clear; 4'hC change-password; 4'hD-F ignored
match  in  1  Compare result (1 when inpwd==curpwd), combinational from outputs below
inpwd  out  8  entered password {digit1,digit0}
curpwd  out  8  stored password
unlock  out  1  lock open
alarm  out  1  alarm active
fail_cnt  out  2  consecutive failures
digits  out  2  digits currently entered (0..2)
state_o  out  3  FSM state, for display and debug

Behaviour:
- Reset (async assert, sync release) sets: inpwd=0, curpwd=DEFAULT_PWD, unlock=0, alarm=0, fail_cnt=0, digits=0, state=IDLE.
- All outputs are registered.
- States: IDLE(0), ENTRY(1), CHECK(2), OPEN(3), NEW_ENTRY(4), ALARM(5).
- Digit shift: inpwd <= {inpwd[3:0], key_code}. digits saturates at 2. A third digit shifts in and drops the oldest; digits stays 2.
- IDLE:
  - A digit key sets inpwd={4'h0, d} and digits=1, then goes to ENTRY.
  - Any other key is ignored.
- ENTRY:
  - Digit: shift.
  - Clear: inpwd=0, digits=0, go to IDLE.
  - Enter with digits==2: go to CHECK.
  - Enter with digits<2: counts as a failure without going to CHECK. Increment fail_cnt, clear the entry, go to IDLE, or to ALARM if the count reaches MAX_FAIL.
- CHECK: exactly one cycle; match is sampled here. Enter-to-unlock latency is 2 clocks.
  - match=1: unlock=1, fail_cnt=0, go to OPEN.
  - match=0: fail_cnt+1. If the new count == MAX_FAIL, alarm=1 and go to ALARM; otherwise go to IDLE.
  - Either way, inpwd=0 and digits=0 on exit.
  - key_valid during CHECK is dropped.
- OPEN:
  - The timer reloads to OPEN_CYCLES on every key_valid. When it expires, unlock=0 and go to IDLE.
  - Change-password key: go to NEW_ENTRY, unlock stays 1.
  - Clear key: close immediately (unlock=0, go to IDLE).
- NEW_ENTRY:
  - Digits shift as in ENTRY.
  - Enter with digits==2: curpwd <= inpwd, clear the entry, return to OPEN with the timer reloaded.
  - Enter with digits<2, or Clear: discard the entry, curpwd unchanged, return to OPEN.
  - The timer also runs here; on expiry, discard, unlock=0, go to IDLE.
- ALARM:
  - All keys are ignored.
  - After ALARM_CYCLES clocks: alarm=0, fail_cnt=0, go to IDLE.
- Simultaneous events: a key_valid in the same cycle as timer expiry is handled as the key (the timer reloads). Codes D-F are always ignored.
- Reset mid-operation, including during ALARM or NEW_ENTRY, restores curpwd=DEFAULT_PWD. The stored password is not retained across reset.
- fail_cnt never exceeds MAX_FAIL, and never wraps.

Decomposition:
- Shared package lock_pkg:
  - State encoding constants.
  - Key code constants: KEY_ENTER=4'hA, KEY_CLEAR=4'hB, KEY_CHANGE=4'hC.
  - Digit-valid predicate (code <= 9).
- One natural sub-module, lock_timer:
  - Loadable down-counter with a load value input, load and enable inputs, and an expired output.
  - Instantiated once, shared by the OPEN/NEW_ENTRY timeout and the ALARM hold; the FSM selects the load value.
- The Compare block stays external. The bench instantiates both blocks and wires inpwd/curpwd/match between them.

Test Plan:
1. Correct code: after reset, keys 5, 2, A. Expect inpwd=8'h52, CHECK for 1 cycle, unlock=1 two clocks after A, fail_cnt=0. With no keys, unlock=0 after 16 clocks.
2. Wrong code ×3: enter 1,2,A then 3,4,A then 9,9,A. Expect fail_cnt 1, 2, then alarm=1 with fail_cnt=3. Keys during the alarm are ignored. After 32 clocks, alarm=0, fail_cnt=0, state IDLE.
3. Change password: open with 5,2,A, then C, 0, 7, A. Expect curpwd=8'h07 and unlock still 1. After the timeout, 5,2,A fails (fail_cnt=1) and 0,7,A opens.
4. Short entry and clear: keys 5, A → fail_cnt=1, IDLE. Keys 5, B → inpwd=0, fail_cnt unchanged. Keys 1,5,2,A (overflow shift) → inpwd=8'h52, opens.
5. Reset mid-operation: pull rst_n low during NEW_ENTRY after curpwd was changed to 8'h07. Expect all outputs at reset values immediately, asynchronously, and curpwd=8'h52.
6. Timer and key collision: in OPEN, send a key on the cycle the timer expires. Expect unlock to stay 1 and the timer to reload to 16.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the digital-lock keypad controller: FSM encoding,
// key codes and the digit predicate.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ENTRY     = 3'd1,
    ST_CHECK     = 3'd2,
    ST_OPEN      = 3'd3,
    ST_NEW_ENTRY = 3'd4,
    ST_ALARM     = 3'd5
  } lock_state_t;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CHANGE = 4'hC;

  // Wide enough for both the open timeout and the alarm hold.
  localparam int TMR_W = 8;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the open timeout and the alarm hold.
// expired is high while the count sits at zero.
module lock_timer
  import lock_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [TMR_W-1:0] load_val,
  output logic             expired
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/pwd_entry_ctrl.sv
// Keypad-side lock controller: collects two BCD digits, checks them against
// the stored password through the external compare block, and runs the lock.
module pwd_entry_ctrl
  import lock_pkg::*;
#(
  parameter logic [7:0] DEFAULT_PWD  = 8'h52,
  parameter int         MAX_FAIL     = 3,
  parameter int         OPEN_CYCLES  = 16,
  parameter int         ALARM_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       match,
  output logic [7:0] inpwd,
  output logic [7:0] curpwd,
  output logic       unlock,
  output logic       alarm,
  output logic [1:0] fail_cnt,
  output logic [1:0] digits,
  output logic [2:0] state_o
);

  // Timer counts load_val..0 and the FSM acts on the cycle after zero,
  // so loading N-1 gives exactly N clocks.
  localparam logic [TMR_W-1:0] OPEN_LOAD  = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] ALARM_LOAD = TMR_W'(ALARM_CYCLES - 1);
  localparam logic [2:0]       FAIL_MAX   = 3'(MAX_FAIL);

  lock_state_t state, state_n;
  logic [7:0]  inpwd_n, curpwd_n;
  logic        unlock_n, alarm_n;
  logic [1:0]  fail_cnt_n, digits_n;

  logic             tmr_load, tmr_en, tmr_expired;
  logic [TMR_W-1:0] tmr_val;

  logic [7:0] shift_pwd;
  logic [1:0] digits_inc;
  logic [2:0] fail_inc;
  logic       fail_hit;
  logic       key_dig;

  assign shift_pwd  = {inpwd[3:0], key_code};
  assign digits_inc = (digits == 2'd2) ? 2'd2 : digits + 2'd1;
  assign fail_inc   = {1'b0, fail_cnt} + 3'd1;
  assign fail_hit   = (fail_inc >= FAIL_MAX);
  assign key_dig    = key_valid && is_digit(key_code);

  lock_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_n    = state;
    inpwd_n    = inpwd;
    curpwd_n   = curpwd;
    unlock_n   = unlock;
    alarm_n    = alarm;
    fail_cnt_n = fail_cnt;
    digits_n   = digits;
    tmr_load   = 1'b0;
    tmr_val    = OPEN_LOAD;
    tmr_en     = (state == ST_OPEN) || (state == ST_NEW_ENTRY) || (state == ST_ALARM);

    case (state)
      ST_IDLE: begin
        if (key_dig) begin
          inpwd_n  = {4'h0, key_code};
          digits_n = 2'd1;
          state_n  = ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        if (key_dig) begin
          inpwd_n  = shift_pwd;
          digits_n = digits_inc;
        end else if (key_valid && (key_code == KEY_CLEAR)) begin
          inpwd_n  = 8'h00;
          digits_n = 2'd0;
          state_n  = ST_IDLE;
        end else if (key_valid && (key_code == KEY_ENTER)) begin
          if (digits == 2'd2) begin
            state_n = ST_CHECK;
          end else begin
            // A short entry is a failed attempt without a compare.
            inpwd_n  = 8'h00;
            digits_n = 2'd0;
            if (fail_hit) begin
              fail_cnt_n = FAIL_MAX[1:0];
              alarm_n    = 1'b1;
              state_n    = ST_ALARM;
              tmr_load   = 1'b1;
              tmr_val    = ALARM_LOAD;
            end else begin
              fail_cnt_n = fail_inc[1:0];
              state_n    = ST_IDLE;
            end
          end
        end
      end

      ST_CHECK: begin
        inpwd_n  = 8'h00;
        digits_n = 2'd0;
        if (match) begin
          unlock_n   = 1'b1;
          fail_cnt_n = 2'd0;
          state_n    = ST_OPEN;
          tmr_load   = 1'b1;
        end else if (fail_hit) begin
          fail_cnt_n = FAIL_MAX[1:0];
          alarm_n    = 1'b1;
          state_n    = ST_ALARM;
          tmr_load   = 1'b1;
          tmr_val    = ALARM_LOAD;
        end else begin
          fail_cnt_n = fail_inc[1:0];
          state_n    = ST_IDLE;
        end
      end

      ST_OPEN: begin
        // Any key, even an ignored one, keeps the lock open and wins over expiry.
        if (key_valid) begin
          tmr_load = 1'b1;
          if (key_code == KEY_CHANGE) begin
            state_n = ST_NEW_ENTRY;
          end else if (key_code == KEY_CLEAR) begin
            unlock_n = 1'b0;
            state_n  = ST_IDLE;
          end
        end else if (tmr_expired) begin
          unlock_n = 1'b0;
          state_n  = ST_IDLE;
        end
      end

      ST_NEW_ENTRY: begin
        if (key_valid) begin
          tmr_load = 1'b1;
          if (is_digit(key_code)) begin
            inpwd_n  = shift_pwd;
            digits_n = digits_inc;
          end else if (key_code == KEY_ENTER) begin
            if (digits == 2'd2) begin
              curpwd_n = inpwd;
            end
            inpwd_n  = 8'h00;
            digits_n = 2'd0;
            state_n  = ST_OPEN;
          end else if (key_code == KEY_CLEAR) begin
            inpwd_n  = 8'h00;
            digits_n = 2'd0;
            state_n  = ST_OPEN;
          end
        end else if (tmr_expired) begin
          inpwd_n  = 8'h00;
          digits_n = 2'd0;
          unlock_n = 1'b0;
          state_n  = ST_IDLE;
        end
      end

      ST_ALARM: begin
        if (tmr_expired) begin
          alarm_n    = 1'b0;
          fail_cnt_n = 2'd0;
          state_n    = ST_IDLE;
        end
      end

      default: begin
        inpwd_n  = 8'h00;
        digits_n = 2'd0;
        unlock_n = 1'b0;
        alarm_n  = 1'b0;
        state_n  = ST_IDLE;
      end
    endcase
  end

  // The stored password deliberately reverts to the default on every reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      inpwd    <= 8'h00;
      curpwd   <= DEFAULT_PWD;
      unlock   <= 1'b0;
      alarm    <= 1'b0;
      fail_cnt <= 2'd0;
      digits   <= 2'd0;
    end else begin
      state    <= state_n;
      inpwd    <= inpwd_n;
      curpwd   <= curpwd_n;
      unlock   <= unlock_n;
      alarm    <= alarm_n;
      fail_cnt <= fail_cnt_n;
      digits   <= digits_n;
    end
  end

  assign state_o = state;

endmodule
